// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one requester port of the memory arbiter.
// master = requester side, slave = arbiter side.
interface mem_arbiter_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ack;
   logic [31:0] rdata;
   logic        err;

   modport master (
      output req, we, addr, wdata,
      input  ack, rdata, err
   );

   modport slave (
      input  req, we, addr, wdata,
      output ack, rdata, err
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares DMEM and GPIO between two requesters via IDLE/ISSUE/RESP.
// Define MEM_ARB_RR_EN for round-robin grants; default is fixed p0 > p1.
module mem_arbiter #(
   parameter int ADDR_W   = 8,
   parameter int GPIO_BIT = 31
) (
   input  logic              clk,
   input  logic              rst,
   mem_arbiter_if.slave      p0,
   mem_arbiter_if.slave      p1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_we,
   input  logic [31:0]       mem_q,
   output logic              gpio_we,
   output logic [31:0]       gpio_wdata,
   input  logic [31:0]       gpio_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              owner_q, owner_d;
   logic              we_q, we_d;
   logic              sel_q, sel_d;
   logic              mis_q, mis_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              mem_we_q, mem_we_d;
   logic              gpio_we_q, gpio_we_d;
   logic [31:0]       rd0_q, rd0_d;
   logic [31:0]       rd1_q, rd1_d;

   logic              grant1;
   logic              req_we;
   logic              req_sel;
   logic              req_mis;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic [31:0]       resp_val;

`ifdef MEM_ARB_RR_EN
   logic              ptr_q, ptr_d;

   // ptr_q is the last granted port; on contention the other one wins
   assign grant1 = p1.req & (~p0.req | ~ptr_q);
`else
   assign grant1 = p1.req & ~p0.req;
`endif

   always_comb begin
      req_we    = grant1 ? p1.we : p0.we;
      req_wdata = grant1 ? p1.wdata : p0.wdata;
      req_addr  = grant1 ? p1.addr[ADDR_W+1:2]
                         : p0.addr[ADDR_W+1:2];
      req_sel   = grant1 ? p1.addr[GPIO_BIT]
                         : p0.addr[GPIO_BIT];
      req_mis   = grant1 ? (|p1.addr[1:0])
                         : (|p0.addr[1:0]);
   end

   assign resp_val = mis_q ? 32'h0
                   : (sel_q ? gpio_rdata : mem_q);

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      we_d      = we_q;
      sel_d     = sel_q;
      mis_d     = mis_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      mem_we_d  = 1'b0;
      gpio_we_d = 1'b0;
      rd0_d     = rd0_q;
      rd1_d     = rd1_q;
`ifdef MEM_ARB_RR_EN
      ptr_d     = ptr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (p0.req | p1.req) begin
               owner_d   = grant1;
               we_d      = req_we;
               sel_d     = req_sel;
               mis_d     = req_mis;
               addr_d    = req_addr;
               wdata_d   = req_wdata;
               mem_we_d  = req_we & ~req_sel & ~req_mis;
               gpio_we_d = req_we & req_sel & ~req_mis;
`ifdef MEM_ARB_RR_EN
               ptr_d     = grant1;
`endif
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            state_d = RESP;
         end
         RESP: begin
            if (!we_q) begin
               if (owner_q) rd1_d = resp_val;
               else         rd0_d = resp_val;
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         owner_q   <= 1'b0;
         we_q      <= 1'b0;
         sel_q     <= 1'b0;
         mis_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= 32'h0;
         mem_we_q  <= 1'b0;
         gpio_we_q <= 1'b0;
         rd0_q     <= 32'h0;
         rd1_q     <= 32'h0;
`ifdef MEM_ARB_RR_EN
         ptr_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         we_q      <= we_d;
         sel_q     <= sel_d;
         mis_q     <= mis_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         mem_we_q  <= mem_we_d;
         gpio_we_q <= gpio_we_d;
         rd0_q     <= rd0_d;
         rd1_q     <= rd1_d;
`ifdef MEM_ARB_RR_EN
         ptr_q     <= ptr_d;
`endif
      end
   end

   // read data is passed through during RESP, then held in rdN_q
   assign p0.ack   = (state_q == RESP) & ~owner_q;
   assign p1.ack   = (state_q == RESP) & owner_q;
   assign p0.err   = p0.ack & mis_q;
   assign p1.err   = p1.ack & mis_q;
   assign p0.rdata = (p0.ack & ~we_q) ? resp_val : rd0_q;
   assign p1.rdata = (p1.ack & ~we_q) ? resp_val : rd1_q;

   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign gpio_wdata = wdata_q;
   assign mem_we     = mem_we_q;
   assign gpio_we    = gpio_we_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench for mem_arbiter,
// with DMEM/GPIO models and a transaction-level reference model.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if p0_if ();
   mem_arbiter_if p1_if ();

   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [31:0] mem_q;
   logic        gpio_we;
   logic [31:0] gpio_wdata;
   logic [31:0] gpio_rdata;
   logic        busy;

   mem_arbiter #(.ADDR_W(8), .GPIO_BIT(31)) dut (
      .clk        (clk),
      .rst        (rst),
      .p0         (p0_if),
      .p1         (p1_if),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_q      (mem_q),
      .gpio_we    (gpio_we),
      .gpio_wdata (gpio_wdata),
      .gpio_rdata (gpio_rdata),
      .busy       (busy)
   );

   // synchronous DMEM and GPIO register
   logic [31:0] dmem [256];
   logic [31:0] gpio_reg;
   bit          clr_mem = 1'b1;

   always @(posedge clk) begin
      if (clr_mem) begin
         for (int i = 0; i < 256; i++) dmem[i] <= 32'h0;
         gpio_reg <= 32'h0;
         mem_q    <= 32'h0;
      end else begin
         if (mem_we) dmem[mem_addr] <= mem_wdata;
         mem_q <= dmem[mem_addr];
         if (gpio_we) gpio_reg <= gpio_wdata;
      end
   end
   assign gpio_rdata = gpio_reg;

   int both_ack = 0;
   int ack_cnt0 = 0;
   int ack_cnt1 = 0;
   always @(negedge clk) begin
      if (p0_if.ack && p1_if.ack) both_ack++;
      if (p0_if.ack) ack_cnt0++;
      if (p1_if.ack) ack_cnt1++;
   end

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   logic [31:0] ref_mem [256];
   logic [31:0] ref_gpio;
   logic [31:0] ref_last [2];
   int          last_grant;

   task automatic drive(input int p, input logic r,
                        input logic w, input logic [31:0] a,
                        input logic [31:0] d);
      if (p == 0) begin
         p0_if.req = r; p0_if.we = w;
         p0_if.addr = a; p0_if.wdata = d;
      end else begin
         p1_if.req = r; p1_if.we = w;
         p1_if.addr = a; p1_if.wdata = d;
      end
   endtask

   function automatic logic ack_of(input int p);
      return (p == 0) ? p0_if.ack : p1_if.ack;
   endfunction

   function automatic logic [31:0] rdata_of(input int p);
      return (p == 0) ? p0_if.rdata : p1_if.rdata;
   endfunction

   function automatic logic err_of(input int p);
      return (p == 0) ? p0_if.err : p1_if.err;
   endfunction

   // one uncontended access; ISSUE-cycle outputs captured for checking
   task automatic access(input int p, input logic w,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic er,
                         output int lat, output logic iss_mw,
                         output logic iss_gw,
                         output logic [7:0] iss_ma,
                         output logic [31:0] iss_wd,
                         output logic [31:0] iss_gwd,
                         output logic resp_strb);
      bit got;
      rd = 32'hx; er = 1'bx; lat = -1;
      iss_mw = 1'bx; iss_gw = 1'bx; iss_ma = 8'hx;
      iss_wd = 32'hx; iss_gwd = 32'hx; resp_strb = 1'bx;
      got = 1'b0;
      @(negedge clk);
      drive(p, 1'b1, w, a, d);
      for (int c = 1; c <= 10 && !got; c++) begin
         @(negedge clk);
         if (c == 1) begin
            iss_mw = mem_we; iss_gw = gpio_we;
            iss_ma = mem_addr; iss_wd = mem_wdata;
            iss_gwd = gpio_wdata;
         end
         if (ack_of(p)) begin
            got = 1'b1; lat = c;
            rd = rdata_of(p); er = err_of(p);
            resp_strb = mem_we | gpio_we;
            drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
         end
      end
      if (!got) drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
      last_grant = p;
   endtask

   // transaction-level model of one access
   task automatic ref_apply(input int p, input logic w,
                            input logic [31:0] a,
                            input logic [31:0] d,
                            output logic [31:0] e_rd,
                            output logic e_err, output logic e_mw,
                            output logic e_gw,
                            output logic [7:0] e_ma);
      logic mis, gp;
      mis = (a % 4) != 0;
      gp = a[31];
      e_err = mis;
      e_ma = 8'((a / 4) % 256);
      e_mw = w && !gp && !mis;
      e_gw = w && gp && !mis;
      if (!w) begin
         if (mis) ref_last[p] = 32'h0;
         else if (gp) ref_last[p] = ref_gpio;
         else ref_last[p] = ref_mem[(a / 4) % 256];
      end else if (!mis) begin
         if (gp) ref_gpio = d;
         else ref_mem[(a / 4) % 256] = d;
      end
      e_rd = ref_last[p];
   endtask

   logic [31:0] rd, iss_wd, iss_gwd, e_rd;
   logic        er, iss_mw, iss_gw, resp_strb;
   logic        e_err, e_mw, e_gw;
   logic [7:0]  iss_ma, e_ma;
   int          lat;

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_busy: got %b exp 0", busy);
      end
      vectors++;
      if ({mem_we, gpio_we} !== 2'b00) begin
         miscompares++;
         $display("FAIL rst_we: got %b exp 00", {mem_we, gpio_we});
      end
      vectors++;
      if ({p0_if.ack, p1_if.ack, p0_if.err, p1_if.err} !== 4'h0)
      begin
         miscompares++;
         $display("FAIL rst_ack: got %b exp 0000",
                  {p0_if.ack, p1_if.ack, p0_if.err, p1_if.err});
      end
      vectors++;
      if ({p0_if.rdata, p1_if.rdata} !== 64'h0) begin
         miscompares++;
         $display("FAIL rst_rdata: got %h %h exp 0",
                  p0_if.rdata, p1_if.rdata);
      end
      vectors++;
      if ({mem_addr, mem_wdata, gpio_wdata} !== 72'h0) begin
         miscompares++;
         $display("FAIL rst_bus: got %h %h %h exp 0",
                  mem_addr, mem_wdata, gpio_wdata);
      end
      clr_mem = 1'b0;
      rst = 1'b1;
      ref_last[0] = 32'h0; ref_last[1] = 32'h0;
      last_grant = 0;
   endtask

   task automatic test_dmem_rw();
      access(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat,
             iss_mw, iss_gw, iss_ma, iss_wd, iss_gwd, resp_strb);
      ref_apply(0, 1'b1, 32'h10, 32'hDEADBEEF,
                e_rd, e_err, e_mw, e_gw, e_ma);
      vectors++;
      if ({iss_mw, iss_gw, iss_ma} !== {2'b10, 8'd4}) begin
         miscompares++;
         $display("FAIL wr_issue: got we=%b gwe=%b a=%0d exp 1 0 4",
                  iss_mw, iss_gw, iss_ma);
      end
      vectors++;
      if (iss_wd !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL wr_wdata: got %h exp deadbeef", iss_wd);
      end
      vectors++;
      if (lat !== 2 || resp_strb !== 1'b0 || er !== 1'b0) begin
         miscompares++;
         $display("FAIL wr_ack: got lat=%0d strb=%b err=%b exp 2 0 0",
                  lat, resp_strb, er);
      end
      access(0, 1'b0, 32'h10, 32'h0, rd, er, lat,
             iss_mw, iss_gw, iss_ma, iss_wd, iss_gwd, resp_strb);
      ref_apply(0, 1'b0, 32'h10, 32'h0,
                e_rd, e_err, e_mw, e_gw, e_ma);
      vectors++;
      if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 2) begin
         miscompares++;
         $display("FAIL rd_back: got %h err=%b lat=%0d exp deadbeef 0 2",
                  rd, er, lat);
      end
      vectors++;
      if (iss_mw !== 1'b0) begin
         miscompares++;
         $display("FAIL rd_nostrobe: got %b exp 0", iss_mw);
      end
   endtask

   task automatic test_gpio();
      access(1, 1'b1, 32'h8000_0000, 32'h1, rd, er, lat,
             iss_mw, iss_gw, iss_ma, iss_wd, iss_gwd, resp_strb);
      ref_apply(1, 1'b1, 32'h8000_0000, 32'h1,
                e_rd, e_err, e_mw, e_gw, e_ma);
      vectors++;
      if ({iss_gw, iss_mw} !== 2'b10 || iss_gwd !== 32'h1) begin
         miscompares++;
         $display("FAIL gpio_wr: got gwe=%b we=%b d=%h exp 1 0 1",
                  iss_gw, iss_mw, iss_gwd);
      end
      vectors++;
      if (lat !== 2 || resp_strb !== 1'b0) begin
         miscompares++;
         $display("FAIL gpio_ack: got lat=%0d strb=%b exp 2 0",
                  lat, resp_strb);
      end
      access(1, 1'b0, 32'h8000_0000, 32'h0, rd, er, lat,
             iss_mw, iss_gw, iss_ma, iss_wd, iss_gwd, resp_strb);
      ref_apply(1, 1'b0, 32'h8000_0000, 32'h0,
                e_rd, e_err, e_mw, e_gw, e_ma);
      vectors++;
      if (rd !== e_rd) begin
         miscompares++;
         $display("FAIL gpio_rd: got %h exp %h", rd, e_rd);
      end
   endtask

   task automatic test_misaligned();
      access(0, 1'b0, 32'h6, 32'h0, rd, er, lat,
             iss_mw, iss_gw, iss_ma, iss_wd, iss_gwd, resp_strb);
      ref_apply(0, 1'b0, 32'h6, 32'h0,
                e_rd, e_err, e_mw, e_gw, e_ma);
      vectors++;
      if (rd !== 32'h0 || er !== 1'b1 || lat !== 2) begin
         miscompares++;
         $display("FAIL mis_rd: got %h err=%b lat=%0d exp 0 1 2",
                  rd, er, lat);
      end
      access(0, 1'b1, 32'h13, 32'h1234, rd, er, lat,
             iss_mw, iss_gw, iss_ma, iss_wd, iss_gwd, resp_strb);
      ref_apply(0, 1'b1, 32'h13, 32'h1234,
                e_rd, e_err, e_mw, e_gw, e_ma);
      vectors++;
      if ({iss_mw, iss_gw, er} !== 3'b001) begin
         miscompares++;
         $display("FAIL mis_wr: got we=%b gwe=%b err=%b exp 0 0 1",
                  iss_mw, iss_gw, er);
      end
   endtask

   task automatic test_wrap();
      access(0, 1'b1, 32'h400, 32'hCAFE0400, rd, er, lat,
             iss_mw, iss_gw, iss_ma, iss_wd, iss_gwd, resp_strb);
      ref_apply(0, 1'b1, 32'h400, 32'hCAFE0400,
                e_rd, e_err, e_mw, e_gw, e_ma);
      vectors++;
      if (iss_ma !== 8'd0 || iss_mw !== 1'b1) begin
         miscompares++;
         $display("FAIL wrap_addr: got a=%0d we=%b exp 0 1",
                  iss_ma, iss_mw);
      end
      access(0, 1'b0, 32'h0, 32'h0, rd, er, lat,
             iss_mw, iss_gw, iss_ma, iss_wd, iss_gwd, resp_strb);
      ref_apply(0, 1'b0, 32'h0, 32'h0,
                e_rd, e_err, e_mw, e_gw, e_ma);
      vectors++;
      if (rd !== 32'hCAFE0400) begin
         miscompares++;
         $display("FAIL wrap_rd: got %h exp cafe0400", rd);
      end
   endtask

   task automatic test_reset_mid();
      int a0, a1;
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 32'h20, 32'h5555_AAAA);
      @(negedge clk);
      vectors++;
      if (mem_we !== 1'b1 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_issue: got we=%b busy=%b exp 1 1",
                  mem_we, busy);
      end
      #2 rst = 1'b0;
      #1;
      vectors++;
      if ({mem_we, gpio_we, busy, p0_if.ack} !== 4'b0000) begin
         miscompares++;
         $display("FAIL mid_abort: got we=%b gwe=%b busy=%b ack=%b exp 0",
                  mem_we, gpio_we, busy, p0_if.ack);
      end
      vectors++;
      if (p0_if.rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL mid_rdata: got %h exp 0", p0_if.rdata);
      end
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      a0 = ack_cnt0; a1 = ack_cnt1;
      repeat (3) @(negedge clk);
      vectors++;
      if (ack_cnt0 != a0 || ack_cnt1 != a1) begin
         miscompares++;
         $display("FAIL mid_noack: got %0d acks exp 0",
                  ack_cnt0 - a0 + ack_cnt1 - a1);
      end
      rst = 1'b1;
      ref_last[0] = 32'h0; ref_last[1] = 32'h0;
      last_grant = 0;
      access(0, 1'b0, 32'h20, 32'h0, rd, er, lat,
             iss_mw, iss_gw, iss_ma, iss_wd, iss_gwd, resp_strb);
      ref_apply(0, 1'b0, 32'h20, 32'h0,
                e_rd, e_err, e_mw, e_gw, e_ma);
      vectors++;
      if (rd !== e_rd || lat !== 2) begin
         miscompares++;
         $display("FAIL mid_after: got %h lat=%0d exp %h 2",
                  rd, lat, e_rd);
      end
   endtask

   logic [31:0] caddr [2][4];
   logic [31:0] crd   [2][4];
   int          order [$];

   task automatic requester(input int p);
      bit got;
      for (int i = 0; i < 4; i++) begin
         got = 1'b0;
         drive(p, 1'b1, 1'b0, caddr[p][i], 32'h0);
         for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (ack_of(p)) begin
               got = 1'b1;
               crd[p][i] = rdata_of(p);
               order.push_back(p);
            end
         end
         if (!got) break;
      end
      drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic test_contest();
      int exp_order [$];
      int n0, n1, lg, w, b0;
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < 4; i++)
            caddr[p][i] = {22'($urandom), 8'($urandom), 2'b00} &
                          32'h7FFF_FFFF;
      n0 = 4; n1 = 4; lg = last_grant;
      while (n0 + n1 > 0) begin
         if (n0 > 0 && n1 > 0) begin
`ifdef MEM_ARB_RR_EN
            w = (lg == 0) ? 1 : 0;
`else
            w = 0;
`endif
         end else begin
            w = (n0 > 0) ? 0 : 1;
         end
         exp_order.push_back(w);
         if (w == 1) n1--; else n0--;
         lg = w;
      end
      order.delete();
      b0 = both_ack;
      @(negedge clk);
      fork
         requester(0);
         requester(1);
      join
      vectors++;
      if (order.size() != 8) begin
         miscompares++;
         $display("FAIL rr_count: got %0d acks exp 8", order.size());
      end
      for (int k = 0; k < 8 && k < order.size(); k++) begin
         vectors++;
         if (order[k] != exp_order[k]) begin
            miscompares++;
            $display("FAIL rr_order[%0d]: got p%0d exp p%0d",
                     k, order[k], exp_order[k]);
         end
      end
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (crd[p][i] !== ref_mem[caddr[p][i][9:2]]) begin
               miscompares++;
               $display("FAIL rr_rdata p%0d[%0d]: got %h exp %h",
                        p, i, crd[p][i], ref_mem[caddr[p][i][9:2]]);
            end
         end
      vectors++;
      if (both_ack != b0) begin
         miscompares++;
         $display("FAIL rr_simul_ack: got %0d exp 0", both_ack - b0);
      end
      for (int p = 0; p < 2; p++)
         ref_last[p] = ref_mem[caddr[p][3][9:2]];
      last_grant = exp_order[7];
   endtask

   task automatic test_random();
      logic [31:0] a, d;
      logic        w;
      int          p, k;
      for (int n = 0; n < 60; n++) begin
         p = $urandom_range(0, 1);
         w = 1'($urandom);
         d = $urandom;
         k = $urandom_range(0, 3);
         case (k)
            0, 1: a = {1'b0, 21'($urandom), 8'($urandom), 2'b00};
            2:    a = {1'b1, 29'($urandom), 2'b00};
            default: begin
               a = $urandom;
               if (a[1:0] == 2'b00) a[0] = 1'b1;
            end
         endcase
         access(p, w, a, d, rd, er, lat,
                iss_mw, iss_gw, iss_ma, iss_wd, iss_gwd, resp_strb);
         ref_apply(p, w, a, d, e_rd, e_err, e_mw, e_gw, e_ma);
         vectors++;
         if (rd !== e_rd || er !== e_err) begin
            miscompares++;
            $display("FAIL rnd%0d p%0d a=%h: got %h err=%b exp %h %b",
                     n, p, a, rd, er, e_rd, e_err);
         end
         vectors++;
         if ({iss_mw, iss_gw, iss_ma} !== {e_mw, e_gw, e_ma}) begin
            miscompares++;
            $display("FAIL rnd%0d strobe: got %b %b %h exp %b %b %h",
                     n, iss_mw, iss_gw, iss_ma, e_mw, e_gw, e_ma);
         end
         vectors++;
         if (lat !== 2 || resp_strb !== 1'b0 || iss_wd !== d) begin
            miscompares++;
            $display("FAIL rnd%0d timing: got lat=%0d strb=%b wd=%h",
                     n, lat, resp_strb, iss_wd);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
      ref_gpio = 32'h0;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      test_reset();
      test_dmem_rw();
      test_gpio();
      test_misaligned();
      test_wrap();
      test_reset_mid();
      test_random();
      test_contest();
      vectors++;
      if (both_ack != 0) begin
         miscompares++;
         $display("FAIL simul_ack_total: got %0d exp 0", both_ack);
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
